// File: rtl/atanh_pkg.sv
// Shared definitions for the iterative atanh unit: default sizes, FSM
// encoding and the 1/(2k+1) reciprocal table used by the series terms.
package atanh_pkg;

  localparam int W      = 16;
  localparam int NTERMS = 6;

  typedef enum logic [2:0] {
    IDLE,
    SQR,
    TERM,
    POW,
    DONE
  } state_t;

  // round(2^16/(2k+1)); k=0 would be 2^16, clamped to the largest Q0.16 value
  function automatic logic [15:0] recip(input logic [2:0] k);
    case (k)
      3'd0:    recip = 16'hFFFF;
      3'd1:    recip = 16'h5555;
      3'd2:    recip = 16'h3333;
      3'd3:    recip = 16'h2492;
      3'd4:    recip = 16'h1C72;
      3'd5:    recip = 16'h1746;
      3'd6:    recip = 16'h13B1;
      default: recip = 16'h1111;
    endcase
  endfunction

endpackage

// File: rtl/atanh_mul16.sv
// Combinational unsigned W x W multiply keeping only the upper W bits
// (Q0.W x Q0.W -> Q0.W, truncated).
module atanh_mul16 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);

  logic [2*W-1:0] full;

  assign full = a * b;
  assign p    = full[2*W-1:W];

endmodule

// File: rtl/atanhcal.sv
// Iterative fixed-point atanh(x) = sum x^(2k+1)/(2k+1), one state per clock,
// sharing a single multiplier across squaring, power and reciprocal steps.
module atanhcal
  import atanh_pkg::*;
#(
  parameter int W      = atanh_pkg::W,
  parameter int NTERMS = atanh_pkg::NTERMS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] Xbus,
  output logic         ready,
  output logic [W-1:0] Rbus
);

  state_t         state, state_nxt;
  logic [W-1:0]   x, x2, pow;
  logic [W:0]     acc;
  logic [2:0]     k;
  logic [W-1:0]   mul_a, mul_b, mul_p;
  logic [W+1:0]   sum;
  logic           last_term;

  assign last_term = (k == 3'(NTERMS - 1));

  // NOTE: every variable assigned in always_comb gets a default first;
  // otherwise a path that skips the assignment would infer a latch.
  always_comb begin
    mul_a     = '0;
    mul_b     = '0;
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SQR;
      SQR: begin
        mul_a     = x;
        mul_b     = x;
        state_nxt = TERM;
      end
      TERM: begin
        mul_a     = pow;
        mul_b     = W'(recip(k));
        state_nxt = last_term ? DONE : POW;
      end
      POW: begin
        mul_a     = pow;
        mul_b     = x2;
        state_nxt = TERM;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  atanh_mul16 #(.W(W)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // A saturated acc (bit W set) always carries again, so it stays pinned.
  assign sum = {1'b0, acc} + {2'b00, mul_p};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ready <= 1'b1;
      Rbus  <= '0;
      x     <= '0;
      x2    <= '0;
      pow   <= '0;
      acc   <= '0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          x     <= Xbus;
          ready <= 1'b0;
        end
        SQR: begin
          x2  <= mul_p;
          pow <= x;
          acc <= '0;
          k   <= '0;
        end
        TERM: begin
          acc <= (sum[W+1:W] != 2'b00) ? '1 : sum[W:0];
          if (!last_term) k <= k + 3'd1;
        end
        POW:  pow <= mul_p;
        DONE: begin
          Rbus  <= acc[W-1:0];
          ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atanhcal.sv
// Self-checking bench for atanhcal: directed boundary/handshake steps plus
// random operands compared against a series-arithmetic reference model.
module tb_atanhcal;

  localparam int W      = 16;
  localparam int NTERMS = 6;
  localparam int LAT    = 2 * NTERMS + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] Xbus;
  logic         ready;
  logic [W-1:0] Rbus;

  int n_assert = 0;
  int n_fail   = 0;

  atanhcal #(.W(W), .NTERMS(NTERMS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Xbus  (Xbus),
    .ready (ready),
    .Rbus  (Rbus)
  );

  always #5 clk = ~clk;

  // Reference: truncated Q0.16 series, reciprocals derived from 2^16/(2k+1)
  function automatic logic [15:0] model(input logic [15:0] xin);
    longint unsigned xv, x2, p, acc, r;
    bit sat;
    xv  = xin;
    x2  = (xv * xv) >> 16;
    p   = xv;
    acc = 0;
    sat = 0;
    for (int i = 0; i < NTERMS; i++) begin
      r = ((131072 / (2 * i + 1)) + 1) / 2;
      if (r > 65535) r = 65535;
      acc += (p * r) >> 16;
      if (acc > 65535) sat = 1;
      if (i < NTERMS - 1) p = (p * x2) >> 16;
    end
    return sat ? 16'hFFFF : acc[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input logic [15:0] obs,
                           input logic [15:0] target, input int tol);
    int d;
    d = int'(obs) - int'(target);
    if (d < 0) d = -d;
    n_assert++;
    assert ((d <= tol) === 1'b1)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h +/- %0d", tag, obs, target, tol);
    end
  endtask

  // Count edges after the accept edge until ready rises (bounded).
  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!ready && edges < 100);
  endtask

  // One job: start pulsed for the accept edge only; checks latency and value.
  task automatic run_job(input string tag, input logic [15:0] xv, output logic [15:0] res);
    int edges;
    Xbus  = xv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    Xbus  = ~xv;
    check({tag, "_busy"}, ready, 1'b0);
    wait_done(edges);
    check({tag, "_lat"}, edges, LAT);
    check({tag, "_val"}, Rbus, model(xv));
    res = Rbus;
  endtask

  initial begin
    logic [15:0] res, xa, xb;
    int edges;

    rst   = 1'b0;
    start = 1'b0;
    Xbus  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", ready, 1'b1);
    check("reset_rbus", Rbus, 16'h0000);
    rst = 1'b1;

    // Zero operand
    @(posedge clk); #1;
    run_job("zero", 16'h0000, res);
    check("zero_abs", res, 16'h0000);

    // 1/3 and 0.5 against true atanh values
    run_job("third", 16'h5555, res);
    check_tol("third_acc", res, 16'h58B9, 8);
    run_job("half", 16'h8000, res);
    check_tol("half_acc", res, 16'h8C9F, 16);

    // Saturation near 1
    run_job("sat", 16'hFFFF, res);
    check("sat_abs", res, 16'hFFFF);

    // Loopback of tanh(1/3) ~ 16'h524F should return ~1/3
    run_job("loop", 16'h524F, res);
    check_tol("loop_acc", res, 16'h5555, 24);

    // Asynchronous reset in the middle of a job (state TERM)
    Xbus  = 16'h4000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("midrst_ready", ready, 1'b1);
    check("midrst_rbus", Rbus, 16'h0000);
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("idle_hold", ready, 1'b1);
    end
    check("idle_rbus", Rbus, 16'h0000);

    // Level start held across a whole job; Xbus changes mid-job
    xa    = 16'h3000;
    xb    = 16'h6789;
    Xbus  = xa;
    start = 1'b1;
    @(posedge clk); #1;
    Xbus = xb;
    wait_done(edges);
    check("hold_lat1", edges, LAT);
    check("hold_val1", Rbus, model(xa));
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_restart", ready, 1'b0);
    check("hold_rbus_stable", Rbus, model(xa));
    wait_done(edges);
    check("hold_lat2", edges, LAT);
    check("hold_val2", Rbus, model(xb));

    // Random operands against the reference model
    for (int i = 0; i < 12; i++) begin
      run_job("rand", 16'($urandom_range(0, 16'hFFFF)), res);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
